// File: rtl/tenc_network_harness_if.sv
// Edge-port bundle for the test-engine network harness: inbound/outbound
// packet buses, per-row handshakes and the traffic counters.
interface tenc_network_harness_if #(
   parameter int Y_WIDTH = 5,
   parameter int PW      = 48
);
   logic [Y_WIDTH*PW-1:0] xneg_in_data,  xpos_in_data;
   logic [Y_WIDTH-1:0]    xneg_in_valid, xpos_in_valid;
   logic [Y_WIDTH-1:0]    xneg_in_ready, xpos_in_ready;
   logic [Y_WIDTH*PW-1:0] xneg_out_data, xpos_out_data;
   logic [Y_WIDTH-1:0]    xneg_out_valid, xpos_out_valid;
   logic [Y_WIDTH*32-1:0] xneg_sent_count, xpos_sent_count;
   logic [Y_WIDTH*32-1:0] xneg_recv_count, xpos_recv_count;
   logic [31:0]           drop_count;

   modport master (
      output xneg_in_data, xpos_in_data, xneg_in_valid, xpos_in_valid,
      input  xneg_in_ready, xpos_in_ready, xneg_out_data, xpos_out_data,
      input  xneg_out_valid, xpos_out_valid, xneg_sent_count, xpos_sent_count,
      input  xneg_recv_count, xpos_recv_count, drop_count
   );

   modport slave (
      input  xneg_in_data, xpos_in_data, xneg_in_valid, xpos_in_valid,
      output xneg_in_ready, xpos_in_ready, xneg_out_data, xpos_out_data,
      output xneg_out_valid, xpos_out_valid, xneg_sent_count, xpos_sent_count,
      output xneg_recv_count, xpos_recv_count, drop_count
   );
endinterface

// File: rtl/tenc_network_harness.sv
// Test-engine network stand-in: one hold-and-forward engine per edge port,
// round-robin output arbitration per edge output, traffic counters.
module tenc_engine #(
   parameter int X_WIDTH     = 5,
   parameter int Y_WIDTH     = 5,
   parameter int PROC_CYCLES = 16,
   parameter int PW          = 48,
   parameter int PTW         = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [PW-1:0]  i_data,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic           i_gnt,
   output logic           o_req,
   output logic           o_drop,
   output logic [PTW-1:0] o_tgt,
   output logic [PW-1:0]  o_data,
   output logic [31:0]    o_sent
);
   localparam int CW = $clog2(PROC_CYCLES + 1);
   localparam logic [3:0] XG_POS = 4'(X_WIDTH);
   localparam logic [3:0] YG_MAX = 4'(Y_WIDTH);

   typedef enum logic [1:0] {IDLE, PROC, WAIT} st_t;

   st_t           r_st;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] r_data;
   logic [31:0]   r_sent;

   logic [3:0]     w_xg, w_yg;
   logic           w_xneg, w_xpos, w_gate_ok;
   logic [PTW-1:0] w_row;

   assign w_xg      = r_data[39:36];
   assign w_yg      = r_data[35:32];
   assign w_xneg    = (w_xg == 4'd1);
   assign w_xpos    = (w_xg == XG_POS) && !w_xneg;
   assign w_gate_ok = (w_xneg || w_xpos) && (w_yg >= 4'd1) && (w_yg <= YG_MAX);
   assign w_row     = PTW'(w_yg - 4'd1);

   assign o_tgt   = w_xpos ? w_row + PTW'(Y_WIDTH) : w_row;
   assign o_req   = (r_st == WAIT) && w_gate_ok;
   assign o_drop  = (r_st == WAIT) && !w_gate_ok;
   // Ready is gated by reset so it drops immediately on assertion.
   assign o_ready = reset && (r_st == IDLE);
   assign o_data  = r_data;
   assign o_sent  = r_sent;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st   <= IDLE;
         r_cnt  <= '0;
         r_data <= '0;
         r_sent <= '0;
      end else begin
         case (r_st)
            IDLE: if (i_valid) begin
               r_data <= i_data;
               r_cnt  <= CW'(PROC_CYCLES - 1);
               r_sent <= r_sent + 32'd1;
               r_st   <= PROC;
            end
            PROC: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                  else             r_st  <= WAIT;
            WAIT: if (!w_gate_ok || i_gnt) r_st <= IDLE;
            default: r_st <= IDLE;
         endcase
      end
   end
endmodule

module tenc_network_harness #(
   parameter int X_WIDTH     = 5,
   parameter int Y_WIDTH     = 5,
   parameter int PROC_CYCLES = 16,
   parameter int PW          = 48
) (
   input logic                          clk,
   input logic                          reset,
   tenc_network_harness_if.slave        bus
);
   localparam int NP  = 2 * Y_WIDTH;
   localparam int PTW = (NP > 1) ? $clog2(NP) : 1;

   logic [NP-1:0][PW-1:0]  w_in_data, w_eng_data, r_out_data;
   logic [NP-1:0]          w_in_valid, w_ready, w_req, w_drop, w_gnt, w_found, r_out_valid;
   logic [NP-1:0][PTW-1:0] w_tgt, w_win, r_ptr;
   logic [NP-1:0][31:0]    w_sent, r_recv;
   logic [31:0]            r_drop, w_drop_cnt;

   // Port p: xneg row r is p=r, xpos row r is p=Y_WIDTH+r.
   for (genvar r = 0; r < Y_WIDTH; r++) begin : g_map
      assign w_in_data[r]           = bus.xneg_in_data[r*PW +: PW];
      assign w_in_data[Y_WIDTH+r]   = bus.xpos_in_data[r*PW +: PW];
      assign w_in_valid[r]          = bus.xneg_in_valid[r];
      assign w_in_valid[Y_WIDTH+r]  = bus.xpos_in_valid[r];
      assign bus.xneg_in_ready[r]   = w_ready[r];
      assign bus.xpos_in_ready[r]   = w_ready[Y_WIDTH+r];
      assign bus.xneg_out_data[r*PW +: PW] = r_out_data[r];
      assign bus.xpos_out_data[r*PW +: PW] = r_out_data[Y_WIDTH+r];
      assign bus.xneg_out_valid[r]  = r_out_valid[r];
      assign bus.xpos_out_valid[r]  = r_out_valid[Y_WIDTH+r];
      assign bus.xneg_sent_count[r*32 +: 32] = w_sent[r];
      assign bus.xpos_sent_count[r*32 +: 32] = w_sent[Y_WIDTH+r];
      assign bus.xneg_recv_count[r*32 +: 32] = r_recv[r];
      assign bus.xpos_recv_count[r*32 +: 32] = r_recv[Y_WIDTH+r];
   end
   assign bus.drop_count = r_drop;

   for (genvar p = 0; p < NP; p++) begin : g_eng
      tenc_engine #(
         .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .PROC_CYCLES(PROC_CYCLES),
         .PW(PW), .PTW(PTW)
      ) u_eng (
         .clk(clk), .reset(reset),
         .i_data(w_in_data[p]), .i_valid(w_in_valid[p]), .o_ready(w_ready[p]),
         .i_gnt(w_gnt[p]), .o_req(w_req[p]), .o_drop(w_drop[p]),
         .o_tgt(w_tgt[p]), .o_data(w_eng_data[p]), .o_sent(w_sent[p])
      );
   end

   // Per output: first requester at or after the pointer, wrapping.
   always_comb begin
      int idx;
      idx        = 0;
      w_found    = '0;
      w_win      = '0;
      w_gnt      = '0;
      w_drop_cnt = '0;
      for (int o = 0; o < NP; o++) begin
         for (int k = 0; k < NP; k++) begin
            idx = int'(r_ptr[o]) + k;
            if (idx >= NP) idx = idx - NP;
            if (!w_found[o] && w_req[idx] && (w_tgt[idx] == PTW'(o))) begin
               w_found[o] = 1'b1;
               w_win[o]   = PTW'(idx);
            end
         end
         if (w_found[o]) w_gnt[w_win[o]] = 1'b1;
      end
      for (int e = 0; e < NP; e++) w_drop_cnt = w_drop_cnt + 32'(w_drop[e]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr       <= '0;
         r_out_data  <= '0;
         r_out_valid <= '0;
         r_recv      <= '0;
         r_drop      <= '0;
      end else begin
         r_drop <= r_drop + w_drop_cnt;
         for (int o = 0; o < NP; o++) begin
            r_out_valid[o] <= w_found[o];
            if (w_found[o]) begin
               r_out_data[o] <= w_eng_data[w_win[o]];
               r_recv[o]     <= r_recv[o] + 32'd1;
               r_ptr[o]      <= (w_win[o] == PTW'(NP - 1)) ? '0 : w_win[o] + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_tenc_network_harness.sv
// Directed bench for tenc_network_harness: latency, sustained rate,
// round-robin contention, invalid gates, bulk traffic and mid-run reset.
module tb_tenc_network_harness;
   localparam int YW = 5;
   localparam int PW = 48;
   localparam int NP = 2 * YW;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   tenc_network_harness_if #(.Y_WIDTH(YW), .PW(PW)) bus ();

   tenc_network_harness #(
      .X_WIDTH(5), .Y_WIDTH(YW), .PROC_CYCLES(16), .PW(PW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] pkt(input logic [3:0] xg, input logic [3:0] yg,
                                       input logic [31:0] s);
      return {4'hA, 4'h5, xg, yg, s};
   endfunction

   task automatic set_in(input int p, input logic [47:0] d, input logic v);
      if (p < YW) begin
         bus.xneg_in_data[p*PW +: PW] = d;
         bus.xneg_in_valid[p]         = v;
      end else begin
         bus.xpos_in_data[(p-YW)*PW +: PW] = d;
         bus.xpos_in_valid[p-YW]           = v;
      end
   endtask

   function automatic logic rdy(input int p);
      return (p < YW) ? bus.xneg_in_ready[p] : bus.xpos_in_ready[p-YW];
   endfunction
   function automatic logic ov(input int p);
      return (p < YW) ? bus.xneg_out_valid[p] : bus.xpos_out_valid[p-YW];
   endfunction
   function automatic logic [47:0] od(input int p);
      return (p < YW) ? bus.xneg_out_data[p*PW +: PW] : bus.xpos_out_data[(p-YW)*PW +: PW];
   endfunction
   function automatic logic [31:0] sent(input int p);
      return (p < YW) ? bus.xneg_sent_count[p*32 +: 32] : bus.xpos_sent_count[(p-YW)*32 +: 32];
   endfunction
   function automatic logic [31:0] recv(input int p);
      return (p < YW) ? bus.xneg_recv_count[p*32 +: 32] : bus.xpos_recv_count[(p-YW)*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] base_recv [NP];
      logic [31:0] sum_s, sum_r;
      int          cnt [NP];
      logic        fire [NP];
      int          done, cyc;
      logic        any_ov;

      bus.xneg_in_data  = '0; bus.xpos_in_data  = '0;
      bus.xneg_in_valid = '0; bus.xpos_in_valid = '0;

      // Reset state
      #1;
      chk("rst_ready", {bus.xpos_in_ready, bus.xneg_in_ready}, '0);
      chk("rst_ovalid", {bus.xpos_out_valid, bus.xneg_out_valid}, '0);
      chk("rst_odata0", od(0), '0);
      chk("rst_drop", bus.drop_count, '0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rel_ready", {bus.xpos_in_ready, bus.xneg_in_ready}, 10'h3FF);

      // Uncontended latency: xneg row 0, gate (1,1)
      set_in(0, pkt(4'd1, 4'd1, 32'd0), 1'b1);
      tick();
      set_in(0, '0, 1'b0);
      chk("lat_busy", rdy(0), 1'b0);
      repeat (16) tick();
      chk("lat_early", ov(0), 1'b0);
      tick();
      chk("lat_valid", ov(0), 1'b1);
      chk("lat_data", od(0), pkt(4'd1, 4'd1, 32'd0));
      chk("lat_sent", sent(0), 32'd1);
      chk("lat_recv", recv(0), 32'd1);
      chk("lat_ready", rdy(0), 1'b1);
      tick();
      chk("lat_strobe", ov(0), 1'b0);

      // Sustained rate: xpos row 2 (port 7) to itself, valid held high
      set_in(7, pkt(4'd5, 4'd3, 32'd0), 1'b1);
      tick();
      for (int i = 0; i < 10; i++) begin
         set_in(7, pkt(4'd5, 4'd3, 32'(i + 1)), 1'b1);
         repeat (16) tick();
         chk($sformatf("rate_gap%0d", i), ov(7), 1'b0);
         tick();
         chk($sformatf("rate_pulse%0d", i), {ov(7), od(7)}, {1'b1, pkt(4'd5, 4'd3, 32'(i))});
         if (i == 9) set_in(7, '0, 1'b0);
         tick();
      end
      chk("rate_sent", sent(7), 32'd10);
      chk("rate_recv", recv(7), 32'd10);

      // Contention: all ports to xpos row 0 (port 5), two bursts
      for (int b = 0; b < 2; b++) begin
         for (int p = 0; p < NP; p++) set_in(p, pkt(4'd5, 4'd1, 32'(b*16 + p)), 1'b1);
         tick();
         for (int p = 0; p < NP; p++) set_in(p, '0, 1'b0);
         repeat (15) tick();
         chk($sformatf("rr%0d_early", b), ov(5), 1'b0);
         tick();
         for (int j = 0; j < NP; j++) begin
            tick();
            chk($sformatf("rr%0d_slot%0d", b, j), {ov(5), od(5)},
                {1'b1, pkt(4'd5, 4'd1, 32'(b*16 + j))});
         end
      end
      tick();
      chk("rr_after", ov(5), 1'b0);
      chk("rr_recv", recv(5), 32'd20);

      // Invalid gates: (3,2) on port 1, (1,0) on port 3
      set_in(1, pkt(4'd3, 4'd2, 32'h11), 1'b1);
      set_in(3, pkt(4'd1, 4'd0, 32'h33), 1'b1);
      tick();
      set_in(1, '0, 1'b0);
      set_in(3, '0, 1'b0);
      any_ov = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         any_ov |= |{bus.xpos_out_valid, bus.xneg_out_valid};
      end
      chk("drop_busy", {rdy(1), rdy(3)}, 2'b00);
      tick();
      chk("drop_count", bus.drop_count, 32'd2);
      chk("drop_ready", {rdy(1), rdy(3)}, 2'b11);
      tick();
      any_ov |= |{bus.xpos_out_valid, bus.xneg_out_valid};
      chk("drop_noout", any_ov, 1'b0);

      // Bulk traffic: 50 packets per port, gates cycling over all outputs
      for (int p = 0; p < NP; p++) begin
         base_recv[p] = recv(p);
         cnt[p] = 0;
      end
      done = 0;
      cyc  = 0;
      while (done < NP * 50 && cyc < 5000) begin
         for (int p = 0; p < NP; p++) begin
            int g;
            g = (p + cnt[p]) % NP;
            fire[p] = rdy(p) && (cnt[p] < 50);
            if (g < YW) set_in(p, pkt(4'd1, 4'(g + 1), 32'(p*100 + cnt[p])), fire[p]);
            else        set_in(p, pkt(4'd5, 4'(NP - g), 32'(p*100 + cnt[p])), fire[p]);
         end
         tick();
         cyc++;
         for (int p = 0; p < NP; p++) if (fire[p]) begin
            cnt[p]++;
            done++;
         end
      end
      for (int p = 0; p < NP; p++) set_in(p, '0, 1'b0);
      chk("bulk_inject", done, NP * 50);
      repeat (300) tick();
      sum_r = '0;
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("bulk_recv%0d", p), recv(p) - base_recv[p], 32'd50);
         sum_r += recv(p);
      end
      chk("bulk_recv_sum", sum_r, 32'd500 + 32'd1 + 32'd10 + 32'd20);
      sum_s = '0;
      for (int p = 0; p < NP; p++) sum_s += sent(p);
      chk("bulk_sent_sum", sum_s, 32'd500 + 32'd1 + 32'd10 + 32'd20 + 32'd2);
      chk("bulk_drop", bus.drop_count, 32'd2);

      // Reset while three engines are in PROC
      for (int p = 0; p < 3; p++) set_in(p, pkt(4'd1, 4'd1, 32'(p)), 1'b1);
      tick();
      for (int p = 0; p < 3; p++) set_in(p, '0, 1'b0);
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("mrst_ready", {bus.xpos_in_ready, bus.xneg_in_ready}, '0);
      chk("mrst_sent0", sent(0), 32'd0);
      chk("mrst_recv5", recv(5), 32'd0);
      chk("mrst_drop", bus.drop_count, 32'd0);
      tick();
      reset = 1'b1;
      #1;
      chk("mrst_rel_ready", {bus.xpos_in_ready, bus.xneg_in_ready}, 10'h3FF);
      any_ov = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         any_ov |= |{bus.xpos_out_valid, bus.xneg_out_valid};
      end
      chk("mrst_noout", any_ov, 1'b0);
      chk("mrst_recv0", recv(0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
